alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one 64-bit RISC-V ALU between two requesters, such as the integer pipeline and the address-generation path. Each requester presents two operands and a 4-bit ALU control code over a valid/ready handshake. The block grants one request per cycle, evaluates it on the ALU, and holds the result in a one-entry output register. The result is returned with the requester ID over a valid/ready response channel.

## Interface
- `W`, 64: operand and result width.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 2: bit i means requester i presents a request.
- `req_ready` output 2: bit i means requester i's request is accepted this cycle.
- `req_a0`, `req_b0` input W each: requester 0 operands.
- `req_a1`, `req_b1` input W each: requester 1 operands.
- `req_ctrl0`, `req_ctrl1` input 4 each: ALU control code per requester.
- `resp_valid` output 1: the output register holds a result.
- `resp_ready` input 1: the consumer accepts the result.
- `resp_id` output 1: the requester that owns the held result.
- `resp_result` output W: the ALU result.
- `resp_zero` output 1: high when `resp_result` equals 0.
- `resp_err` output 1: high when the control code was unsupported.

## Operation
- Control codes:
  - 4'b0010 selects ADD, a + b.
  - 4'b0110 selects SUB, a − b.
  - 4'b0000 selects AND.
  - 4'b0001 selects OR.
- Any other code gives result 0, zero 1 and err 1.
- ADD and SUB wrap modulo 2^W; there is no carry or overflow output.
- The output register is "free" when `!resp_valid || resp_ready`.
- Arbitration is combinational:
  - With one requester valid, that requester is granted.
  - With both valid, the requester selected by the priority pointer `prio` is granted.
  - No grant is made when the output register is not free.
- `req_ready[i]` = grant_i && free. At most one bit of `req_ready` is high.
  - `req_ready` does not depend on `req_valid` of the same requester beyond the grant computation.
- Accept: when `req_valid[i] && req_ready[i]`:
  - The ALU result of that requester's operands loads into the output register on the same edge.
  - `resp_id` is set to i and `resp_valid` is set to 1.
- Priority pointer: after every accept, `prio` is set to the non-granted requester, whether or not that requester was contending. With no accept, `prio` holds.
- Response: when `resp_valid && resp_ready && !accept`, `resp_valid` clears.
- Simultaneous drain and accept in the same cycle:
  - The new result replaces the old one.
  - `resp_valid` stays 1.
  - This sustains one result per cycle.
- Backpressure: while `resp_valid && !resp_ready`, both `req_ready` bits are low and the held result is stable.
- Requester obligation: a requester holding `req_valid` must keep its operands and control code stable until accepted.
- Reset (rst=1 at an edge):
  - `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_zero`=0, `resp_err`=0, `prio`=0.
  - `req_ready` is forced to 0 while rst is high.
  - A result held at reset is discarded without being delivered.

## Timing
- Latency is 1 cycle. A request accepted at edge N has its response visible after edge N.
- The ALU is combinational between the operand mux and the output register. The critical path is mux, then 64-bit adder, then the zero-detect OR-reduce.
- Throughput is 1 request per cycle while `resp_ready` stays high.
- Fairness: with both requesters continuously valid and `resp_ready` high, grants strictly alternate 0, 1, 0, 1, …
- `resp_*` outputs come only from registers. `req_ready` is combinational from `req_valid`, `resp_valid`, `resp_ready` and `prio`.

## Structure
- The shared package `alu_pkg` holds:
  - A typedef for the 4-bit control codes: `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_SUB`=0110.
  - The parameter `XLEN`=64.
- One sub-module, `alu_core`, is combinational: inputs a, b, ctrl; outputs result, zero, err. It is instantiated once in the arbiter.
- The arbiter itself contains the grant logic, operand mux, priority flop and output register.

## Test plan
- Reset and idle: assert rst 2 cycles with both requesters valid. Expect `req_ready`=00 and all resp outputs 0. After release, requester 0 is granted first.
- Single op set:
  - From req0: a=5, b=5, ctrl=0110. Expect resp_result=0, zero=1, id=0, one cycle later.
  - Then ADD with a=FFFF_FFFF_FFFF_FFFF, b=1. Expect result 0 and zero=1 (wrap).
- Unsupported code: ctrl=1111 with a=3, b=4. Expect result 0, zero=1, err=1.
- Contention:
  - Hold both valid, with req0 doing AND F0&3C and req1 doing OR F0|3C, and `resp_ready`=1.
  - Expect alternating responses 30 (id 0), FC (id 1), 30, FC.
- Backpressure:
  - Hold `resp_ready`=0 for 3 cycles after an accept.
  - Expect `req_ready`=00 and a stable result during that time.
  - Raising `resp_ready` accepts the next request on the same edge, with no bubble.
- Reset mid-operation: assert rst while `resp_valid`=1 and `resp_ready`=0. Expect `resp_valid`=0 on the next cycle and the result never delivered.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and datapath width
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_ctrl_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational RISC-V ALU slice (ADD/SUB/AND/OR) with zero and error flags
module alu_core
    import alu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   ctrl,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         err
);

    logic [W-1:0] w_result;
    logic         w_err;

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (ctrl)
            ALU_ADD: w_result = a + b;
            ALU_SUB: w_result = a - b;
            ALU_AND: w_result = a & b;
            ALU_OR:  w_result = a | b;
            default: w_err    = 1'b1;
        endcase
    end

    assign result = w_result;
    // Unsupported codes yield result 0, so zero is naturally 1 for them as well.
    assign zero   = (w_result == '0);
    assign err    = w_err;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters with a one-entry result register
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic [3:0]   req_ctrl0,
    input  logic [3:0]   req_ctrl1,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_result,
    output logic         resp_zero,
    output logic         resp_err
);

    logic         r_prio;
    logic         r_resp_valid;
    logic         r_resp_id;
    logic [W-1:0] r_resp_result;
    logic         r_resp_zero;
    logic         r_resp_err;

    logic         w_free;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_accept;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [3:0]   w_ctrl;
    logic [W-1:0] w_alu_result;
    logic         w_alu_zero;
    logic         w_alu_err;

    // A draining result frees the register in the same cycle, giving one result per cycle.
    assign w_free   = !r_resp_valid || resp_ready;
    assign w_grant0 = req_valid[0] && (!req_valid[1] || !r_prio);
    assign w_grant1 = req_valid[1] && (!req_valid[0] ||  r_prio);

    assign req_ready = {w_grant1, w_grant0} & {2{w_free && !rst}};
    assign w_accept  = |(req_valid & req_ready);

    assign w_a    = w_grant1 ? req_a1    : req_a0;
    assign w_b    = w_grant1 ? req_b1    : req_b0;
    assign w_ctrl = w_grant1 ? req_ctrl1 : req_ctrl0;

    alu_core #(.W(W)) u_alu_core (
        .a      (w_a),
        .b      (w_b),
        .ctrl   (w_ctrl),
        .result (w_alu_result),
        .zero   (w_alu_zero),
        .err    (w_alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio        <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_err    <= 1'b0;
        end else if (w_accept) begin
            r_prio        <= !w_grant1;
            r_resp_valid  <= 1'b1;
            r_resp_id     <= w_grant1;
            r_resp_result <= w_alu_result;
            r_resp_zero   <= w_alu_zero;
            r_resp_err    <= w_alu_err;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_ctrl0, req_ctrl1;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [63:0] resp_result;

    int pass_cnt = 0;
    int total_cnt = 0;

    // behavioural model state
    logic        m_valid, m_id, m_zero, m_err, m_prio;
    logic [63:0] m_result;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_ctrl0   (req_ctrl0),
        .req_ctrl1   (req_ctrl1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err)
    );

    function automatic logic [65:0] alu_ref(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        logic [63:0] r;
        logic        e;
        e = 1'b0;
        r = 64'd0;
        if (c == 4'd2)      r = a + b;
        else if (c == 4'd6) r = a - b;
        else if (c == 4'd0) r = a & b;
        else if (c == 4'd1) r = a | b;
        else                e = 1'b1;
        return {r, (r == 64'd0), e};
    endfunction

    function automatic logic [1:0] exp_ready();
        if (rst || (m_valid && !resp_ready)) return 2'b00;
        if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    function automatic logic [67:0] exp_resp();
        return {m_valid, m_id, m_result, m_zero, m_err};
    endfunction

    function automatic logic [67:0] got_resp();
        return {resp_valid, resp_id, resp_result, resp_zero, resp_err};
    endfunction

    task automatic model_commit();
        logic [1:0]  g;
        logic [65:0] r;
        g = exp_ready() & req_valid;
        if (rst) begin
            {m_valid, m_id, m_result, m_zero, m_err, m_prio} = '0;
        end else if (g != 2'b00) begin
            r = g[1] ? alu_ref(req_a1, req_b1, req_ctrl1) : alu_ref(req_a0, req_b0, req_ctrl0);
            {m_result, m_zero, m_err} = r;
            m_valid = 1'b1;
            m_id    = g[1];
            m_prio  = !g[1];
        end else if (m_valid && resp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // inputs are changed at the falling edge; outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
        req_a0 = 64'd1; req_b0 = 64'd2; req_ctrl0 = 4'd2;
        req_a1 = 64'd3; req_b1 = 64'd4; req_ctrl1 = 4'd2;
        #1;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (req_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (got_resp() !== 68'd0) $display("FAIL reset_resp got %h exp 0", got_resp());
            else pass_cnt++;
        end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL reset_first_grant got %b exp 01", req_ready);
        else pass_cnt++;
        req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_single_ops();
        req_valid = 2'b01; req_a0 = 64'd5; req_b0 = 64'd5; req_ctrl0 = 4'b0110;
        tick();
        total_cnt++;
        if (got_resp() !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0})
            $display("FAIL sub_zero got %h exp %h", got_resp(), {1'b1, 1'b0, 64'd0, 1'b1, 1'b0});
        else pass_cnt++;
        req_a0 = 64'hFFFF_FFFF_FFFF_FFFF; req_b0 = 64'd1; req_ctrl0 = 4'b0010;
        tick();
        total_cnt++;
        if (got_resp() !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0})
            $display("FAIL add_wrap got %h exp %h", got_resp(), {1'b1, 1'b0, 64'd0, 1'b1, 1'b0});
        else pass_cnt++;
        req_a0 = 64'd3; req_b0 = 64'd5; req_ctrl0 = 4'b0110;
        tick();
        total_cnt++;
        if (resp_result !== 64'hFFFF_FFFF_FFFF_FFFE || resp_zero !== 1'b0)
            $display("FAIL sub_neg got %h/%b exp fffffffffffffffe/0", resp_result, resp_zero);
        else pass_cnt++;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_unsupported();
        req_valid = 2'b10; req_a1 = 64'd3; req_b1 = 64'd4; req_ctrl1 = 4'b1111;
        tick();
        total_cnt++;
        if (got_resp() !== {1'b1, 1'b1, 64'd0, 1'b1, 1'b1})
            $display("FAIL unsupported got %h exp %h", got_resp(), {1'b1, 1'b1, 64'd0, 1'b1, 1'b1});
        else pass_cnt++;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        logic [63:0] exp_r;
        req_valid = 2'b11; resp_ready = 1'b1;
        req_a0 = 64'hF0; req_b0 = 64'h3C; req_ctrl0 = 4'b0000;
        req_a1 = 64'hF0; req_b1 = 64'h3C; req_ctrl1 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_r = (i % 2 == 0) ? 64'h30 : 64'hFC;
            total_cnt++;
            if (resp_result !== exp_r || resp_id !== 1'(i % 2) || resp_valid !== 1'b1)
                $display("FAIL contention_%0d got id %b res %h exp id %0d res %h", i, resp_id, resp_result, i % 2, exp_r);
            else pass_cnt++;
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back_backpressure();
        logic [63:0] held;
        req_valid = 2'b01; resp_ready = 1'b1;
        req_a0 = 64'd100; req_b0 = 64'd23; req_ctrl0 = 4'b0010;
        tick();
        held = 64'd123;
        resp_ready = 1'b0;
        req_valid = 2'b11;
        req_a0 = 64'd7; req_b0 = 64'd2; req_ctrl0 = 4'b0110;
        req_a1 = 64'h0F; req_b1 = 64'hF0; req_ctrl1 = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (req_ready !== 2'b00) $display("FAIL bp_ready_%0d got %b exp 00", i, req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (resp_result !== held || resp_valid !== 1'b1) $display("FAIL bp_hold_%0d got %h exp %h", i, resp_result, held);
            else pass_cnt++;
        end
        resp_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 2'b10) $display("FAIL bp_release_ready got %b exp 10", req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (resp_result !== 64'hFF || resp_id !== 1'b1 || resp_valid !== 1'b1)
            $display("FAIL bp_release_resp got %h id %b exp ff id 1", resp_result, resp_id);
        else pass_cnt++;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] acc;
        logic [3:0] codes [5];
        codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2; codes[3] = 4'd6; codes[4] = 4'd9;
        for (int n = 0; n < 300; n++) begin
            // a requester with an unaccepted request keeps it stable
            if (!(req_valid[0] && !acc[0]) || n == 0) begin
                req_valid[0] = 1'($urandom_range(0, 3) != 0);
                req_a0 = {$urandom, $urandom}; req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : {$urandom, $urandom};
                req_ctrl0 = codes[$urandom_range(0, 4)];
            end
            if (!(req_valid[1] && !acc[1]) || n == 0) begin
                req_valid[1] = 1'($urandom_range(0, 3) != 0);
                req_a1 = {$urandom, $urandom}; req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : {$urandom, $urandom};
                req_ctrl1 = codes[$urandom_range(0, 4)];
            end
            resp_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            total_cnt++;
            if (req_ready !== exp_ready()) $display("FAIL rand_ready_%0d got %b exp %b", n, req_ready, exp_ready());
            else pass_cnt++;
            acc = req_valid & exp_ready();
            tick();
            total_cnt++;
            if (got_resp() !== exp_resp()) $display("FAIL rand_resp_%0d got %h exp %h", n, got_resp(), exp_resp());
            else pass_cnt++;
        end
        req_valid = 2'b00; resp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; resp_ready = 1'b1;
        req_a0 = 64'd40; req_b0 = 64'd2; req_ctrl0 = 4'b0010;
        tick();
        req_valid = 2'b00; resp_ready = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (resp_valid !== 1'b1 || req_ready !== 2'b00)
            $display("FAIL midrst_pre got valid %b ready %b exp 1 00", resp_valid, req_ready);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (got_resp() !== 68'd0) $display("FAIL midrst_clear got %h exp 0", got_resp());
        else pass_cnt++;
        resp_ready = 1'b1;
        tick();
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL midrst_no_deliver got %b exp 0", resp_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_unsupported();
        test_contention();
        test_back_to_back_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
